// File: rtl/encoder_pkg.sv
// Shared definitions for the request encoder family.
// Supplies the default index width and the one-hot helper used to
// regenerate a grant vector from an encoded index.
package encoder_pkg;

    localparam int DEFAULT_INPUT_SIZE = 5;

    // Widest index the one-hot helper supports; callers narrow the
    // result to their own vector width with a size cast.
    localparam int MAX_INPUT_SIZE = 10;

    function automatic logic [2**MAX_INPUT_SIZE-1:0] onehot_of(
        input logic [MAX_INPUT_SIZE-1:0] idx
    );
        logic [2**MAX_INPUT_SIZE-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/prio_encoder.sv
// Combinational fixed-priority encoder: reports the index of the lowest
// set bit of a 2**INPUT_SIZE-bit vector plus a flag saying any bit was set.
module prio_encoder #(
    parameter int INPUT_SIZE = 5
) (
    input  logic [2**INPUT_SIZE-1:0] vector,
    output logic [INPUT_SIZE-1:0]    index,
    output logic                     found
);

    localparam int N = 2**INPUT_SIZE;

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        index = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vector[i]) begin
                index = INPUT_SIZE'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_encoder.sv
// Registered round-robin priority encoder with a one-entry valid/ready
// output register. Compresses a request vector into the index of one
// granted requester plus its one-hot decode.
// Build option: define RR_ENCODER_ROUND_ROBIN_EN for round-robin
// selection; without it the lowest set request always wins and the
// priority pointer is not built.
module rr_encoder
    import encoder_pkg::*;
#(
    parameter int INPUT_SIZE = DEFAULT_INPUT_SIZE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [2**INPUT_SIZE-1:0] req,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INPUT_SIZE-1:0]    out,
    output logic [2**INPUT_SIZE-1:0] out_onehot
);

    localparam int N = 2**INPUT_SIZE;

    logic [INPUT_SIZE-1:0] sel_idx;
    logic                  any_req;
    logic [INPUT_SIZE-1:0] unmasked_idx;
    logic                  load;

    // The unmasked encoder doubles as the "any request" detector.
    prio_encoder #(
        .INPUT_SIZE(INPUT_SIZE)
    ) u_unmasked (
        .vector(req),
        .index (unmasked_idx),
        .found (any_req)
    );

`ifdef RR_ENCODER_ROUND_ROBIN_EN

    logic [INPUT_SIZE-1:0] ptr;
    logic [N-1:0]          masked_req;
    logic [INPUT_SIZE-1:0] masked_idx;
    logic                  masked_found;

    // Only requests at or above the pointer compete in the masked encode.
    assign masked_req = req & ({N{1'b1}} << ptr);

    prio_encoder #(
        .INPUT_SIZE(INPUT_SIZE)
    ) u_masked (
        .vector(masked_req),
        .index (masked_idx),
        .found (masked_found)
    );

    // Masked winner takes precedence; otherwise wrap to the lowest request.
    assign sel_idx = masked_found ? masked_idx : unmasked_idx;

    // Advance the pointer just past each grant; the natural width overflow
    // wraps a grant of the top index back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= sel_idx + INPUT_SIZE'(1);
        end
    end

`else

    assign sel_idx = unmasked_idx;

`endif

    // New index is captured only when there is something to encode and the
    // output slot is empty or being drained this cycle.
    assign load = enable && any_req && (!out_valid || out_ready);

    // One-entry output register: load replaces, acceptance alone empties,
    // otherwise the entry is held stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out        <= '0;
            out_onehot <= '0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out        <= sel_idx;
            out_onehot <= N'(onehot_of(MAX_INPUT_SIZE'(sel_idx)));
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
            out        <= '0;
            out_onehot <= '0;
        end
    end

endmodule

// File: tb/tb_rr_encoder.sv
// Directed testbench for rr_encoder at the default 5-bit index width.
// Expected grant sequences follow the build option RR_ENCODER_ROUND_ROBIN_EN.
module tb_rr_encoder;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [31:0] req;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out;
    logic [31:0] out_onehot;

    int n_cmp;
    int n_fail;

    rr_encoder #(
        .INPUT_SIZE(5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .req       (req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_onehot(out_onehot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        enable    = 1'b0;
        req       = '0;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        enable    = 1'b0;
        req       = '0;
        out_ready = 1'b0;
        #12;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_valid: got %b, expected 0", out_valid);
        end
        n_cmp++;
        if (out !== 5'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_out: got %0d, expected 0", out);
        end
        n_cmp++;
        if (out_onehot !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_onehot: got %h, expected 0", out_onehot);
        end
        step();
        rst    = 1'b0;
        enable = 1'b1;
        req    = 32'h0000_0010;
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out !== 5'd4) begin
            n_fail++;
            $display("[TB] FAIL midhold_load: got v=%b out=%0d, expected v=1 out=4", out_valid, out);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out !== 5'd0 || out_onehot !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL midhold_reset: got v=%b out=%0d oh=%h, expected all 0",
                     out_valid, out, out_onehot);
        end
        step();
        rst       = 1'b0;
        req       = 32'h0000_0003;
        out_ready = 1'b1;
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out !== 5'd0 || out_onehot !== 32'h1) begin
            n_fail++;
            $display("[TB] FAIL post_reset_grant: got v=%b out=%0d oh=%h, expected v=1 out=0 oh=1",
                     out_valid, out, out_onehot);
        end
    endtask

    task automatic test_sweep();
        logic [4:0] exp_seq[5];
`ifdef RR_ENCODER_ROUND_ROBIN_EN
        exp_seq = '{5'd0, 5'd2, 5'd31, 5'd0, 5'd2};
`else
        exp_seq = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
`endif
        do_reset();
        enable    = 1'b1;
        out_ready = 1'b1;
        req       = 32'h8000_0005;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || out !== exp_seq[i] ||
                out_onehot !== (32'h1 << exp_seq[i])) begin
                n_fail++;
                $display("[TB] FAIL sweep_%0d: got v=%b out=%0d oh=%h, expected v=1 out=%0d",
                         i, out_valid, out, out_onehot, exp_seq[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        enable    = 1'b1;
        out_ready = 1'b0;
        req       = 32'h0000_0300;
        step();
        req = 32'h0000_0001;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out !== 5'd8 || out_onehot !== 32'h0000_0100) begin
                n_fail++;
                $display("[TB] FAIL backpressure_hold_%0d: got v=%b out=%0d oh=%h, expected v=1 out=8 oh=100",
                         i, out_valid, out, out_onehot);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out !== 5'd0 || out_onehot !== 32'h1) begin
            n_fail++;
            $display("[TB] FAIL backpressure_release: got v=%b out=%0d oh=%h, expected v=1 out=0 oh=1",
                     out_valid, out, out_onehot);
        end
    endtask

    task automatic test_empty_enable();
        // Entry holding index 0 with out_ready high; empty request drains it.
        req = '0;
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || out !== 5'd0 || out_onehot !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL empty_drain: got v=%b out=%0d oh=%h, expected all 0",
                     out_valid, out, out_onehot);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL empty_stay: got v=%b, expected 0", out_valid);
        end
        out_ready = 1'b0;
        req       = 32'h0000_0004;
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out !== 5'd2) begin
            n_fail++;
            $display("[TB] FAIL enable_load: got v=%b out=%0d, expected v=1 out=2", out_valid, out);
        end
        enable = 1'b0;
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out !== 5'd2 || out_onehot !== 32'h4) begin
            n_fail++;
            $display("[TB] FAIL disabled_hold: got v=%b out=%0d oh=%h, expected v=1 out=2 oh=4",
                     out_valid, out, out_onehot);
        end
        out_ready = 1'b1;
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || out_onehot !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL disabled_accept: got v=%b oh=%h, expected v=0 oh=0", out_valid, out_onehot);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL disabled_no_load: got v=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_wrap();
        logic [4:0] exp_a;
        logic [4:0] exp_b;
`ifdef RR_ENCODER_ROUND_ROBIN_EN
        exp_a = 5'd31;
        exp_b = 5'd0;
`else
        exp_a = 5'd0;
        exp_b = 5'd0;
`endif
        do_reset();
        enable    = 1'b1;
        out_ready = 1'b1;
        req       = 32'h4000_0000;
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out !== 5'd30) begin
            n_fail++;
            $display("[TB] FAIL wrap_setup: got v=%b out=%0d, expected v=1 out=30", out_valid, out);
        end
        req = 32'hC000_0001;
        step();
        n_cmp++;
        if (out !== exp_a || out_onehot !== (32'h1 << exp_a)) begin
            n_fail++;
            $display("[TB] FAIL wrap_top: got out=%0d oh=%h, expected out=%0d", out, out_onehot, exp_a);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out !== exp_b) begin
            n_fail++;
            $display("[TB] FAIL wrap_after: got v=%b out=%0d, expected v=1 out=%0d", out_valid, out, exp_b);
        end
    endtask

    task automatic test_single_top();
        req = 32'h8000_0000;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || out !== 5'd31 || out_onehot !== 32'h8000_0000) begin
                n_fail++;
                $display("[TB] FAIL single_top_%0d: got v=%b out=%0d oh=%h, expected v=1 out=31",
                         i, out_valid, out, out_onehot);
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst       = 1'b1;
        enable    = 1'b0;
        req       = '0;
        out_ready = 1'b0;
        test_reset();
        test_sweep();
        test_backpressure();
        test_empty_enable();
        test_wrap();
        test_single_top();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
